// File: rtl/dbg_uart_host_if.sv
// Interface bundling the requester-side command/data signals and the
// UART byte-stream signals of dbg_uart_host. Signal names keep the
// direction suffixes as seen from the host block itself.
//   slave  : view used by dbg_uart_host
//   master : view used by the requester / UART model driving it
interface dbg_uart_host_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [7:0]  cmd_len_i;
    logic        wdata_valid_i;
    logic [7:0]  wdata_i;
    logic        wdata_ready_o;
    logic        rdata_valid_o;
    logic [7:0]  rdata_o;
    logic        done_o;
    logic        error_o;
    logic        busy_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;

    modport slave (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
        input  wdata_valid_i, wdata_i, tx_ready_i, rx_valid_i, rx_data_i,
        output cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
        output done_o, error_o, busy_o, tx_valid_o, tx_data_o, rx_ready_o
    );

    modport master (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_len_i,
        output wdata_valid_i, wdata_i, tx_ready_i, rx_valid_i, rx_data_i,
        input  cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
        input  done_o, error_o, busy_o, tx_valid_o, tx_data_o, rx_ready_o
    );
endinterface

// File: rtl/dbg_uart_host.sv
// dbg_uart_host: initiator side of the debug UART bridge.
// Serialises read/write commands into request frames
//   opcode (0x10 write / 0x11 read), LEN, ADDR[31:24..7:0], [write data]
// on the TX byte stream and forwards read response bytes from RX.
// Optional feature macro: DBG_UART_HOST_TIMEOUT_EN adds an inter-byte
// timeout while waiting for read response bytes.
module dbg_uart_host #(
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned TIMEOUT_W      = 17
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dbg_uart_host_if.slave   bus
);

    localparam logic [7:0] OPC_WRITE = 8'h10;
    localparam logic [7:0] OPC_READ  = 8'h11;

    // Configuration sanity: the timeout counter must be able to hold its limit.
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES >= (64'd1 << TIMEOUT_W))) begin : g_bad_cfg
        $error("dbg_uart_host: TIMEOUT_W too small for TIMEOUT_CYCLES");
    end

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_OP    = 4'd1,
        ST_LEN   = 4'd2,
        ST_ADDR0 = 4'd3,
        ST_ADDR1 = 4'd4,
        ST_ADDR2 = 4'd5,
        ST_ADDR3 = 4'd6,
        ST_WDATA = 4'd7,
        ST_RDATA = 4'd8,
        ST_DONE  = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q,  addr_d;
    logic [7:0]  len_q,   len_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic        err_q,   err_d;
    logic        tmo_hit_s;

`ifdef DBG_UART_HOST_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

    // Timeout limit reached on a cycle with no response byte.
    always_comb begin
        tmo_hit_s = (state_q == ST_RDATA) && !bus.rx_valid_i &&
                    (tmo_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    end

    // Timeout counter: cleared entering RDATA and on each byte, counts otherwise.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_RDATA) begin
            if (bus.rx_valid_i) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + TIMEOUT_W'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    // Without the timeout feature RDATA waits indefinitely.
    always_comb begin
        tmo_hit_s = 1'b0;
    end
`endif

    // Frame sequencing and command latching (next-state logic).
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid_i) begin
                    write_d = bus.cmd_write_i;
                    addr_d  = bus.cmd_addr_i;
                    len_d   = bus.cmd_len_i;
                    cnt_d   = bus.cmd_len_i;
                    if (bus.cmd_len_i == 8'd0) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_OP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OP:    state_d = bus.tx_ready_i ? ST_LEN   : ST_OP;
            ST_LEN:   state_d = bus.tx_ready_i ? ST_ADDR0 : ST_LEN;
            ST_ADDR0: state_d = bus.tx_ready_i ? ST_ADDR1 : ST_ADDR0;
            ST_ADDR1: state_d = bus.tx_ready_i ? ST_ADDR2 : ST_ADDR1;
            ST_ADDR2: state_d = bus.tx_ready_i ? ST_ADDR3 : ST_ADDR2;
            ST_ADDR3: begin
                if (bus.tx_ready_i) begin
                    state_d = write_q ? ST_WDATA : ST_RDATA;
                end else begin
                    state_d = ST_ADDR3;
                end
            end
            ST_WDATA: begin
                if (bus.wdata_valid_i && bus.tx_ready_i) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_RDATA: begin
                if (bus.rx_valid_i) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end else if (tmo_hit_s) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and command registers; reset abandons any frame in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            addr_q  <= 32'h0000_0000;
            len_q   <= 8'h00;
            cnt_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Output decode; TX data comes only from registers so it is stable while stalled.
    always_comb begin
        bus.cmd_ready_o   = 1'b0;
        bus.busy_o        = 1'b1;
        bus.tx_valid_o    = 1'b0;
        bus.tx_data_o     = 8'h00;
        bus.wdata_ready_o = 1'b0;
        bus.rdata_valid_o = 1'b0;
        bus.rdata_o       = 8'h00;
        bus.done_o        = 1'b0;
        bus.error_o       = 1'b0;
        bus.rx_ready_o    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                bus.cmd_ready_o = 1'b1;
                bus.busy_o      = 1'b0;
            end
            ST_OP: begin
                bus.tx_valid_o = 1'b1;
                bus.tx_data_o  = write_q ? OPC_WRITE : OPC_READ;
            end
            ST_LEN: begin
                bus.tx_valid_o = 1'b1;
                bus.tx_data_o  = len_q;
            end
            ST_ADDR0: begin
                bus.tx_valid_o = 1'b1;
                bus.tx_data_o  = addr_q[31:24];
            end
            ST_ADDR1: begin
                bus.tx_valid_o = 1'b1;
                bus.tx_data_o  = addr_q[23:16];
            end
            ST_ADDR2: begin
                bus.tx_valid_o = 1'b1;
                bus.tx_data_o  = addr_q[15:8];
            end
            ST_ADDR3: begin
                bus.tx_valid_o = 1'b1;
                bus.tx_data_o  = addr_q[7:0];
            end
            ST_WDATA: begin
                bus.tx_valid_o    = bus.wdata_valid_i;
                bus.tx_data_o     = bus.wdata_i;
                bus.wdata_ready_o = bus.tx_ready_i;
            end
            ST_RDATA: begin
                bus.rdata_valid_o = bus.rx_valid_i;
                bus.rdata_o       = bus.rx_valid_i ? bus.rx_data_i : 8'h00;
            end
            ST_DONE: begin
                bus.done_o  = 1'b1;
                bus.error_o = err_q;
            end
            default: begin
                bus.busy_o = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_dbg_uart_host.sv
// Directed self-checking bench for dbg_uart_host.
module tb_dbg_uart_host;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    logic [7:0] exp_b [0:15];
    int         exp_n;

    dbg_uart_host_if bus ();

    dbg_uart_host #(
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_W      (17)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one cycle and check it is accepted.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] len);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = wr;
        bus.cmd_addr_i  = addr;
        bus.cmd_len_i   = len;
        #1;
        chk("cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    // Drive the TX side through exp_b[0..exp_n-1]; bytes 6.. are write data.
    task automatic tx_frame(input string tag, input bit bp);
        int idx;
        int cyc;
        logic rdy;
        idx = 0;
        cyc = 0;
        while ((idx < exp_n) && (cyc < 200)) begin
            rdy = bp ? ((cyc % 3) == 0) : 1'b1;
            bus.tx_ready_i    = rdy;
            bus.wdata_valid_i = (idx >= 6);
            bus.wdata_i       = (idx >= 6) ? exp_b[idx] : 8'h00;
            #1;
            chk({tag, "_txv"},  {31'd0, bus.tx_valid_o}, 32'd1);
            chk({tag, "_txd"},  {24'd0, bus.tx_data_o}, {24'd0, exp_b[idx]});
            chk({tag, "_wrdy"}, {31'd0, bus.wdata_ready_o}, {31'd0, ((idx >= 6) && rdy)});
            chk({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd1);
            if (bus.tx_valid_o && rdy) idx++;
            tick();
            cyc++;
        end
        bus.wdata_valid_i = 1'b0;
        bus.tx_ready_i    = 1'b1;
        chk({tag, "_bytes"}, idx, exp_n);
    endtask

    task automatic expect_done(input string tag, input logic err);
        chk({tag, "_done"}, {31'd0, bus.done_o}, 32'd1);
        chk({tag, "_err"},  {31'd0, bus.error_o}, {31'd0, err});
        tick();
        chk({tag, "_idle_done"}, {31'd0, bus.done_o}, 32'd0);
        chk({tag, "_idle_rdy"},  {31'd0, bus.cmd_ready_o}, 32'd1);
        chk({tag, "_idle_busy"}, {31'd0, bus.busy_o}, 32'd0);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        bus.cmd_valid_i   = 1'b0;
        bus.cmd_write_i   = 1'b0;
        bus.cmd_addr_i    = 32'h0;
        bus.cmd_len_i     = 8'h0;
        bus.wdata_valid_i = 1'b0;
        bus.wdata_i       = 8'h0;
        bus.tx_ready_i    = 1'b1;
        bus.rx_valid_i    = 1'b0;
        bus.rx_data_i     = 8'h0;
        #12;
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
        chk("rst_rx_ready",  {31'd0, bus.rx_ready_o}, 32'd1);
        chk("rst_busy",      {31'd0, bus.busy_o}, 32'd0);
        chk("rst_tx_valid",  {31'd0, bus.tx_valid_o}, 32'd0);
        chk("rst_done",      {31'd0, bus.done_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Write len 3, no backpressure.
        exp_b[0] = 8'h10; exp_b[1] = 8'h03; exp_b[2] = 8'h20; exp_b[3] = 8'h00;
        exp_b[4] = 8'h00; exp_b[5] = 8'h04; exp_b[6] = 8'h11; exp_b[7] = 8'h22;
        exp_b[8] = 8'h33;
        exp_n = 9;
        issue(1'b1, 32'h2000_0004, 8'd3);
        tx_frame("wr", 1'b0);
        expect_done("wr", 1'b0);

        // Same write with 1-on / 2-off TX backpressure.
        issue(1'b1, 32'h2000_0004, 8'd3);
        tx_frame("wrbp", 1'b1);
        expect_done("wrbp", 1'b0);

        // Stray RX byte in IDLE is dropped.
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'h5A;
        #1;
        chk("stray_idle_rv", {31'd0, bus.rdata_valid_o}, 32'd0);
        tick();
        bus.rx_valid_i = 1'b0;
        chk("stray_idle_state", {31'd0, bus.busy_o}, 32'd0);

        // Read len 4.
        exp_b[0] = 8'h11; exp_b[1] = 8'h04; exp_b[2] = 8'hF0; exp_b[3] = 8'h00;
        exp_b[4] = 8'h00; exp_b[5] = 8'h04;
        exp_n = 6;
        issue(1'b0, 32'hF000_0004, 8'd4);
        tx_frame("rd", 1'b0);
        exp_b[0] = 8'h00; exp_b[1] = 8'h00; exp_b[2] = 8'hFE; exp_b[3] = 8'hCA;
        for (int i = 0; i < 4; i++) begin
            bus.rx_valid_i = 1'b0;
            #1;
            chk("rd_gap_rv",  {31'd0, bus.rdata_valid_o}, 32'd0);
            chk("rd_gap_txv", {31'd0, bus.tx_valid_o}, 32'd0);
            tick();
            bus.rx_valid_i = 1'b1;
            bus.rx_data_i  = exp_b[i];
            #1;
            chk("rd_rv", {31'd0, bus.rdata_valid_o}, 32'd1);
            chk("rd_rd", {24'd0, bus.rdata_o}, {24'd0, exp_b[i]});
            tick();
        end
        bus.rx_valid_i = 1'b0;
        expect_done("rd", 1'b0);

        // Zero length command.
        issue(1'b1, 32'h0000_0000, 8'd0);
        chk("zl_txv", {31'd0, bus.tx_valid_o}, 32'd0);
        expect_done("zl", 1'b1);

        // Reset during ADDR1 of a write.
        issue(1'b1, 32'hA1B2_C3D4, 8'd1);
        tick();
        tick();
        tick();
        chk("rmid_addr1", {24'd0, bus.tx_data_o}, 32'h0000_00B2);
        rst_n = 1'b0;
        #1;
        chk("rmid_cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
        chk("rmid_txv",       {31'd0, bus.tx_valid_o}, 32'd0);
        chk("rmid_busy",      {31'd0, bus.busy_o}, 32'd0);
        tick();
        chk("rmid_done", {31'd0, bus.done_o}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rmid_done2", {31'd0, bus.done_o}, 32'd0);
        exp_b[0] = 8'h10; exp_b[1] = 8'h01; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
        exp_b[4] = 8'h01; exp_b[5] = 8'h00; exp_b[6] = 8'h5A;
        exp_n = 7;
        issue(1'b1, 32'h0000_0100, 8'd1);
        tx_frame("post", 1'b0);
        expect_done("post", 1'b0);

`ifdef DBG_UART_HOST_TIMEOUT_EN
        begin
            int k;
            exp_b[0] = 8'h11; exp_b[1] = 8'h02; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
            exp_b[4] = 8'h00; exp_b[5] = 8'h00;
            exp_n = 6;
            issue(1'b0, 32'h0000_0000, 8'd2);
            tx_frame("tmo", 1'b0);
            bus.rx_valid_i = 1'b1;
            bus.rx_data_i  = 8'h77;
            #1;
            chk("tmo_rv", {31'd0, bus.rdata_valid_o}, 32'd1);
            tick();
            bus.rx_valid_i = 1'b0;
            k = 0;
            while ((bus.done_o !== 1'b1) && (k < 100)) begin
                chk("tmo_quiet", {31'd0, bus.rdata_valid_o}, 32'd0);
                tick();
                k++;
            end
            chk("tmo_cycles", k, 16);
            expect_done("tmo", 1'b1);
            bus.rx_valid_i = 1'b1;
            bus.rx_data_i  = 8'h88;
            #1;
            chk("tmo_late_rv", {31'd0, bus.rdata_valid_o}, 32'd0);
            tick();
            bus.rx_valid_i = 1'b0;
            chk("tmo_late_idle", {31'd0, bus.busy_o}, 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dbg_uart_host.md
Name: dbg_uart_host

Overview:
Initiator side of the debug UART bridge protocol. It accepts memory read and write commands from a local requester and serialises each one into a request frame on a byte-wide TX stream. For reads, it collects the response bytes from a byte-wide RX stream and forwards them to the requester. It sits between a local controller (test sequencer or board-level master) and a UART byte core that links to a remote debug bridge.

Parameters:
TIMEOUT_CYCLES, 65536, clk_i cycles allowed between read response bytes (used only with the optional feature)
TIMEOUT_W, 17, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-low
cmd_valid_i  input  1  command request
cmd_ready_o  output  1  command accepted when high with cmd_valid_i
cmd_write_i  input  1  1 = write, 0 = read
cmd_addr_i  input  32  byte start address
cmd_len_i  input  8  byte count, 1..255
wdata_valid_i  input  1  write data byte valid
wdata_i  input  8  write data byte
wdata_ready_o  output  1  write data byte consumed
rdata_valid_o  output  1  read data byte strobe, one cycle, no backpressure
rdata_o  output  8  read data byte
done_o  output  1  one-cycle pulse when a command completes
error_o  output  1  qualifies done_o; 1 = command failed
busy_o  output  1  high in every state except IDLE
tx_valid_o  output  1  byte to UART TX
tx_data_o  output  8  TX byte
tx_ready_i  input  1  UART TX accepts byte
rx_valid_i  input  1  byte from UART RX
rx_data_i  input  8  RX byte
rx_ready_o  output  1  RX byte consumed; tied high, bytes outside RDATA are discarded

Behaviour:
- Clock is clk_i. Reset rst_i is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0 except cmd_ready_o = 1 and rx_ready_o = 1. Reset mid-frame abandons the frame and produces no done_o.
- Frame format: opcode (0x10 write, 0x11 read), then LEN, then ADDR[31:24], [23:16], [15:8], [7:0]. A write frame then carries LEN data bytes. A read frame has the remote side return LEN bytes, lowest address first.
- Byte handshake: a TX byte transfers on the cycle where tx_valid_o and tx_ready_i are both high. tx_data_o must stay stable while tx_valid_o is high and tx_ready_i is low.
- States:
  - IDLE: cmd_ready_o = 1. On cmd_valid_i, latch write/addr/len and load the remaining-byte counter with cmd_len_i. If cmd_len_i == 0, go to DONE with error set. Otherwise go to OP.
  - OP: send opcode, then go to LEN.
  - LEN: send the latched length, then go to ADDR0.
  - ADDR0..ADDR3: send the address bytes MSB first. From ADDR3, go to WDATA (write) or RDATA (read).
  - WDATA: tx_valid_o = wdata_valid_i, tx_data_o = wdata_i, wdata_ready_o = tx_ready_i. Each transfer decrements the counter; the transfer that takes it 1 -> 0 goes to DONE. wdata_ready_o is 0 in all other states.
  - RDATA: each rx_valid_i produces rdata_valid_o/rdata_o in the same cycle (combinational pass-through, zero latency) and decrements the counter. The decrement to 0 goes to DONE.
  - DONE: done_o = 1 and error_o = latched error for exactly one cycle, then IDLE. The error latch clears on entry to IDLE.
- rx_valid_i outside RDATA: byte is dropped, no rdata_valid_o, no state change.
- The counter is 8-bit and only ever counts down from a value of 1..255, so it never wraps.
- No response is expected for writes; done_o fires as soon as the last data byte is accepted by TX.
- A new command may be accepted in the cycle after DONE; there is no command overlap.

Optional Feature:
DBG_UART_HOST_TIMEOUT_EN
- Defined: a TIMEOUT_W counter clears on entry to RDATA and on every rx_valid_i, and increments each cycle in RDATA. Reaching TIMEOUT_CYCLES goes to DONE with error_o = 1. Bytes arriving after the timeout are dropped as stray bytes.
- Not defined: no counter exists; RDATA waits indefinitely. error_o is asserted only for cmd_len_i == 0.

Test Plan:
- Write: len 3, addr 0x20000004, data 0x11 0x22 0x33, tx_ready_i held 1 -> TX sequence 10 03 20 00 00 04 11 22 33 on consecutive cycles; done_o = 1, error_o = 0 one cycle after the last byte.
- Read: len 4, addr 0xF0000004, RX returns 00 00 FE CA -> TX sequence 11 04 F0 00 00 04; rdata stream 00 00 FE CA with 4 strobes; done_o = 1, error_o = 0.
- Backpressure: same write with tx_ready_i toggling 1 cycle on / 2 cycles off -> identical byte order, tx_data_o stable while stalled, wdata_ready_o only on accepted cycles.
- Zero length: cmd_len_i = 0 -> no TX bytes; done_o = 1 and error_o = 1 on the cycle after acceptance.
- Timeout (macro defined, TIMEOUT_CYCLES = 16): read len 2, send one RX byte then silence -> rdata_valid_o once; done_o = 1 with error_o = 1 sixteen cycles later; a later RX byte is ignored.
- Reset mid-op: assert rst_i during ADDR1 of a write -> all outputs return to reset values immediately; no done_o. The next command frames correctly from OP.
